// File: rtl/seg_scan_drv.sv
// seg_scan_drv: 4-digit common-anode 7-seg scanner, frame-synchronous loads.
// Optional SEG_LZ_BLANK_EN blanks leading zero digits (rightmost always shown).
module seg_scan_drv #(
  parameter int unsigned CLK_HZ    = 100000000,
  parameter int unsigned DIGIT_HZ  = 1000,
  parameter int unsigned GUARD_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] din,
  input  logic [3:0]  dp_in,
  input  logic        load,
  input  logic        en,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_tick,
  output logic        upd_ack
);

  localparam int unsigned DWELL = CLK_HZ / DIGIT_HZ;
  localparam int unsigned CW    = (DWELL > 2) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST  = CW'(DWELL - 1);
  localparam logic [CW-1:0] GUARD = CW'(GUARD_CYC);

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic          last_cyc;
  logic          boundary;

  logic [15:0] disp_val;
  logic [3:0]  disp_dp;
  logic [15:0] sh_val;
  logic [3:0]  sh_dp;
  logic        pending;

  logic [3:0]  an_sel;
  logic [3:0]  nib;
  logic        dp_bit;
  logic        blank;
  logic        lit;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    s = 7'b1111111;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  assign last_cyc = (cnt == LAST);
  assign boundary = last_cyc && (idx == 2'd3);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      idx <= 2'd0;
    end else if (last_cyc) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // A load landing on the boundary goes straight to the display.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      disp_val   <= 16'h0000;
      disp_dp    <= 4'b0000;
      sh_val     <= 16'h0000;
      sh_dp      <= 4'b0000;
      pending    <= 1'b0;
      upd_ack    <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= boundary;
      upd_ack    <= 1'b0;
      if (boundary) begin
        pending <= 1'b0;
        if (load) begin
          disp_val <= din;
          disp_dp  <= dp_in;
          upd_ack  <= 1'b1;
        end else if (pending) begin
          disp_val <= sh_val;
          disp_dp  <= sh_dp;
          upd_ack  <= 1'b1;
        end
      end else if (load) begin
        sh_val  <= din;
        sh_dp   <= dp_in;
        pending <= 1'b1;
      end
    end
  end

  always_comb begin
    an_sel = 4'b1111;
    nib    = 4'h0;
    dp_bit = 1'b0;
    unique case (idx)
      2'd0: begin
        an_sel = 4'b0111;
        nib    = disp_val[15:12];
        dp_bit = disp_dp[3];
      end
      2'd1: begin
        an_sel = 4'b1011;
        nib    = disp_val[11:8];
        dp_bit = disp_dp[2];
      end
      2'd2: begin
        an_sel = 4'b1101;
        nib    = disp_val[7:4];
        dp_bit = disp_dp[1];
      end
      2'd3: begin
        an_sel = 4'b1110;
        nib    = disp_val[3:0];
        dp_bit = disp_dp[0];
      end
      default: begin
        an_sel = 4'b1111;
      end
    endcase
  end

`ifdef SEG_LZ_BLANK_EN
  always_comb begin
    blank = 1'b0;
    unique case (idx)
      2'd0: blank = (disp_val[15:12] == 4'h0);
      2'd1: blank = (disp_val[15:8] == 8'h00);
      2'd2: blank = (disp_val[15:4] == 12'h000);
      2'd3: blank = 1'b0;
      default: blank = 1'b0;
    endcase
  end
`else
  assign blank = 1'b0;
`endif

  assign lit = en && (cnt >= GUARD);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an  <= 4'b1111;
      seg <= 7'b1111111;
      dp  <= 1'b1;
    end else begin
      an  <= lit ? an_sel : 4'b1111;
      seg <= blank ? 7'b1111111 : hex7(nib);
      dp  <= ~dp_bit;
    end
  end

endmodule

// File: tb/tb_seg_scan_drv.sv
// tb_seg_scan_drv: directed + random stimulus vs a frame-level reference model.
// DWELL=10, GUARD=2, so one frame is 40 cycles.
module tb_seg_scan_drv;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] din = 16'h0000;
  logic [3:0]  dp_in = 4'b0000;
  logic        load = 1'b0;
  logic        en = 1'b1;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;
  logic        upd_ack;

  int tests = 0;
  int fails = 0;

  int          n;
  logic [15:0] m_disp;
  logic [3:0]  m_dp;
  logic [15:0] m_sh;
  logic [3:0]  m_shdp;
  logic        m_pend;

  logic [6:0] hex_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  seg_scan_drv #(
    .CLK_HZ(1000),
    .DIGIT_HZ(100),
    .GUARD_CYC(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .din(din),
    .dp_in(dp_in),
    .load(load),
    .en(en),
    .an(an),
    .seg(seg),
    .dp(dp),
    .frame_tick(frame_tick),
    .upd_ack(upd_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_an"}, {12'h0, an}, 16'hF);
    chk({tag, "_seg"}, {9'h0, seg}, 16'h7F);
    chk({tag, "_dp"}, {15'h0, dp}, 16'h1);
    chk({tag, "_ft"}, {15'h0, frame_tick}, 16'h0);
    chk({tag, "_ack"}, {15'h0, upd_ack}, 16'h0);
  endtask

  task automatic model_reset();
    n = 0;
    m_disp = 16'h0;
    m_dp = 4'h0;
    m_sh = 16'h0;
    m_shdp = 4'h0;
    m_pend = 1'b0;
  endtask

  // Each call covers one clock: inputs held across the edge, outputs checked 1ns later.
  task automatic step(input logic ld, input logic [15:0] d,
                      input logic [3:0] p, input logic e);
    int ph;
    int ix;
    logic bnd;
    logic [15:0] top;
    logic [3:0] ean;
    logic [6:0] eseg;
    logic edp;
    logic eack;
    load = ld;
    din = d;
    dp_in = p;
    en = e;
    @(posedge clk);
    ph = n % 40;
    ix = ph / 10;
    bnd = (ph == 39);
    ean = (e && (ph % 10) >= 2) ? ~(4'b1000 >> ix) : 4'b1111;
    top = m_disp >> (4 * (3 - ix));
    eseg = hex_tab[top[3:0]];
`ifdef SEG_LZ_BLANK_EN
    if (ix < 3 && top == 16'h0) eseg = 7'b1111111;
`endif
    edp = ~m_dp[3 - ix];
    eack = bnd && (ld || m_pend);
    if (bnd) begin
      if (ld) begin
        m_disp = d;
        m_dp = p;
      end else if (m_pend) begin
        m_disp = m_sh;
        m_dp = m_shdp;
      end
      m_pend = 1'b0;
    end else if (ld) begin
      m_sh = d;
      m_shdp = p;
      m_pend = 1'b1;
    end
    n++;
    #1;
    chk("an", {12'h0, an}, {12'h0, ean});
    chk("seg", {9'h0, seg}, {9'h0, eseg});
    chk("dp", {15'h0, dp}, {15'h0, edp});
    chk("frame_tick", {15'h0, frame_tick}, {15'h0, bnd});
    chk("upd_ack", {15'h0, upd_ack}, {15'h0, eack});
    load = 1'b0;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 16'h0, 4'h0, 1'b1);
  endtask

  task automatic run_to_phase(input int ph);
    for (int i = 0; i < 40 && (n % 40) != ph; i++)
      step(1'b0, 16'h0, 4'h0, 1'b1);
  endtask

  initial begin
    model_reset();
    #2 rst = 1'b0;
    #1 chk_reset("rst_hold");
    @(posedge clk);
    #1 chk_reset("rst_hold2");
    rst = 1'b1;
    model_reset();

    idle(45);

    run_to_phase(15);
    step(1'b1, 16'h1A8F, 4'b0010, 1'b1);
    idle(24 + 45);

    run_to_phase(5);
    step(1'b1, 16'h1111, 4'b0000, 1'b1);
    run_to_phase(20);
    step(1'b1, 16'h2222, 4'b0100, 1'b1);
    run_to_phase(39);
    step(1'b1, 16'h3333, 4'b1000, 1'b1);
    idle(45);

    for (int i = 0; i < 45; i++) step(1'b0, 16'h0, 4'h0, 1'b0);
    idle(45);

    for (int i = 0; i < 400; i++)
      step(($urandom % 6) == 0, 16'($urandom), 4'($urandom),
           ($urandom % 8) != 0);

    run_to_phase(22);
    step(1'b1, 16'h5555, 4'b1111, 1'b1);
    step(1'b0, 16'h0, 4'h0, 1'b1);
    #2 rst = 1'b0;
    #1 chk_reset("rst_async");
    model_reset();
    @(posedge clk);
    #1 chk_reset("rst_async2");
    rst = 1'b1;
    idle(90);

    run_to_phase(10);
    step(1'b1, 16'h0040, 4'b0000, 1'b1);
    idle(90);

    run_to_phase(10);
    step(1'b1, 16'h0000, 4'b0110, 1'b1);
    idle(90);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
